// File: rtl/cpu_defs_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, stall vector layout and
// the instruction-fetch state encoding.
package cpu_defs;

    localparam int INST_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int STALL_W    = 6;
    localparam int STALL_IF   = 0;
    localparam int STALL_IFID = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: combinational lookup, single-word fill.
// Only the valid bits are reset; tag and data contents are don't-care until filled.
module if_icache
    import cpu_defs::*;
#(
    parameter int IDX_W = 7
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              hit,
    output logic [INST_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [INST_W-1:0] fill_data
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [INST_W-1:0] data [LINES];

    logic [IDX_W-1:0] lk_idx, fill_idx;
    logic [TAG_W-1:0] lk_tag, fill_tag;
    logic             unused_lo;

    assign lk_idx    = lk_addr[IDX_W+1:2];
    assign lk_tag    = lk_addr[ADDR_W-1:IDX_W+2];
    assign fill_idx  = fill_addr[IDX_W+1:2];
    assign fill_tag  = fill_addr[ADDR_W-1:IDX_W+2];
    // Instruction words are aligned; the byte offset never participates.
    assign unused_lo = ^{lk_addr[1:0], fill_addr[1:0]};

    assign hit      = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    assign hit_data = data[lk_idx];

    always_ff @(posedge clk_in) begin
        if (rst_in)
            valid <= '0;
        else if (fill_en)
            valid[fill_idx] <= 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// RV32I instruction fetch: four byte reads per word, branch redirect, stall hold.
// Define IF_ICACHE_EN to add a direct-mapped I-cache in front of memory.
module if_fetch
    import cpu_defs::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0,
    parameter int                ICACHE_IDX_W = 7
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic [STALL_W-1:0] stall_in,
    input  logic               branch_or_not,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [7:0]         mem_byte,
    output logic               stall_req,
    output logic [ADDR_W-1:0]  output_pc,
    output logic [INST_W-1:0]  output_instru
);
    fetch_state_t state, state_n;

    logic [ADDR_W-1:0] pc, fetch_pc;
    logic [1:0]        byte_cnt;
    logic [INST_W-1:0] inst_buf;
    logic              flush;
    logic              hit_pend;
    logic              lk_hit;
    logic [INST_W-1:0] lk_data;
    logic              fill_en;
    logic [INST_W-1:0] fill_data;
    logic              unused_stall;

    assign unused_stall = ^stall_in[STALL_W-1:STALL_IF+1];

    // fetch_pc is the PC of the word about to be fetched; only meaningful on
    // edges that enter FETCH, which is where the cache is probed.
    always_comb begin
        state_n  = state;
        fetch_pc = pc;
        case (state)
            IDLE:  state_n = FETCH;
            FETCH: if (hit_pend || (mem_ack && !flush && byte_cnt == 2'd3))
                       state_n = DONE;
            DONE:  if (!stall_in[STALL_IF]) begin
                       state_n  = FETCH;
                       fetch_pc = pc + 32'd4;
                   end
            default: state_n = IDLE;
        endcase
        if (branch_or_not) begin
            state_n  = FETCH;
            fetch_pc = branch_target;
        end
    end

    assign fill_en   = rdy_in && !branch_or_not && (state == FETCH) && !hit_pend &&
                       !flush && mem_ack && (byte_cnt == 2'd3);
    assign fill_data = {mem_byte, inst_buf[23:0]};

`ifdef IF_ICACHE_EN
    if_icache #(.IDX_W(ICACHE_IDX_W)) u_icache (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .lk_addr   (fetch_pc),
        .hit       (lk_hit),
        .hit_data  (lk_data),
        .fill_en   (fill_en),
        .fill_addr (pc),
        .fill_data (fill_data)
    );
`else
    logic unused_cache;
    assign lk_hit       = 1'b0;
    assign lk_data      = '0;
    assign unused_cache = ^{fetch_pc, fill_en, fill_data, (ICACHE_IDX_W > 0)};
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_n;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc            <= RESET_PC;
            byte_cnt      <= 2'd0;
            inst_buf      <= '0;
            flush         <= 1'b0;
            hit_pend      <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            stall_req     <= 1'b0;
            output_pc     <= '0;
            output_instru <= '0;
        end else if (rdy_in) begin
            if (branch_or_not) begin
                // Request drops for one cycle; flush swallows any in-flight ack.
                pc            <= branch_target;
                byte_cnt      <= 2'd0;
                flush         <= 1'b1;
                hit_pend      <= lk_hit;
                inst_buf      <= lk_data;
                mem_req       <= 1'b0;
                stall_req     <= 1'b1;
                output_pc     <= '0;
                output_instru <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        byte_cnt  <= 2'd0;
                        hit_pend  <= lk_hit;
                        inst_buf  <= lk_data;
                        mem_req   <= !lk_hit;
                        mem_addr  <= pc;
                        stall_req <= 1'b1;
                    end
                    FETCH: begin
                        if (hit_pend) begin
                            hit_pend      <= 1'b0;
                            flush         <= 1'b0;
                            mem_req       <= 1'b0;
                            stall_req     <= 1'b0;
                            output_pc     <= pc;
                            output_instru <= inst_buf;
                        end else if (flush) begin
                            flush    <= 1'b0;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                        end else if (mem_ack) begin
                            inst_buf[{byte_cnt, 3'b000} +: 8] <= mem_byte;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                mem_req       <= 1'b0;
                                stall_req     <= 1'b0;
                                output_pc     <= pc;
                                output_instru <= fill_data;
                            end else begin
                                mem_addr <= pc + 32'(byte_cnt) + 32'd1;
                            end
                        end
                    end
                    DONE: begin
                        if (!stall_in[STALL_IF]) begin
                            pc            <= pc + 32'd4;
                            byte_cnt      <= 2'd0;
                            hit_pend      <= lk_hit;
                            inst_buf      <= lk_data;
                            mem_req       <= !lk_hit;
                            mem_addr      <= pc + 32'd4;
                            stall_req     <= 1'b1;
                            output_instru <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RV32I pipeline, directly upstream of the IF/ID register. Holds the program counter, fetches each 32-bit instruction from the byte-wide memory controller as four sequential byte reads, and presents `{pc, instruction}` to IF/ID. Handles EX branch redirects and global stall control, and optionally serves hits from a direct-mapped instruction cache.

## Interface
Parameters:
- `RESET_PC`, default 32'h0: PC loaded on reset.
- `ICACHE_IDX_W`, default 7: index bits of the optional I-cache (128 lines).

Ports:
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `rdy_in`  in  1  global enable; when 0, no state changes (reset still takes effect).
- `stall_in`  in  6  stall vector; bit 0 stalls the PC, bit 1 stalls the IF/ID handoff.
- `branch_or_not`  in  1  EX redirect pulse.
- `branch_target`  in  32  redirect PC; valid with `branch_or_not`.
- `mem_req`  out  1  byte read request.
- `mem_addr`  out  32  byte address of the request.
- `mem_ack`  in  1  `mem_byte` holds the byte for the address requested in the previous ack'd transaction.
- `mem_byte`  in  8  returned byte.
- `stall_req`  out  1  fetch not complete; to stall control.
- `output_pc`  out  32  PC of the presented instruction.
- `output_instru`  out  32  instruction; 0 means bubble.

## Operation
- Reset: `pc = RESET_PC`, state IDLE, `byte_cnt = 0`, `mem_req = 0`, `mem_addr = 0`, `output_pc = 0`, `output_instru = 0`, `stall_req = 0`, flush flag cleared. Cache valid bits cleared.
- States:
  - IDLE → FETCH on the next enabled cycle.
  - FETCH: `mem_req = 1`, `mem_addr = pc + byte_cnt`. Each `mem_ack` stores `mem_byte` into `buf[8*byte_cnt +: 8]` (little-endian) and increments `byte_cnt`. When the ack for `byte_cnt == 3` arrives, go to DONE.
  - DONE: `output_pc = pc`, `output_instru = buf`.
    - If `stall_in[0] == 0`: `pc <= pc + 4`, `byte_cnt <= 0`, next state FETCH.
    - Otherwise stay in DONE and hold the outputs.
- `stall_req = 1` in FETCH, 0 otherwise. `output_instru = 0` in all states except DONE.
- Redirect (`branch_or_not = 1`) has priority over everything except reset:
  - `pc <= branch_target`, `byte_cnt <= 0`, outputs zeroed, `mem_req <= 0` for one cycle, state → FETCH.
  - Any `mem_ack` in the cycle after the redirect is discarded via the flush flag.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC + 4 wraps to 0. Byte addresses `pc + 0..3` also wrap mod 2^32.
- Misaligned `branch_target` is not checked; the low bits are used as given.

## Timing
- Miss latency, with memory ack latency L ≥ 1 per byte: the instruction appears in DONE 4·L cycles after entering FETCH.
- Outputs are registered and change only on clock edges.
- `rdy_in = 0` freezes all registers, including `byte_cnt`. An ack arriving while `rdy_in = 0` is ignored; the memory controller re-acks.
- Reset asserted mid-fetch abandons the fetch immediately. `mem_req` is low on the next cycle.
- A redirect coinciding with the final ack: the redirect wins and the instruction is dropped.

## Configuration
- `IF_ICACHE_EN` defined:
  - Direct-mapped cache with 2^`ICACHE_IDX_W` lines. Index `pc[ICACHE_IDX_W+1:2]`, tag `pc[31:ICACHE_IDX_W+2]`.
  - Lookup happens in the cycle of entering FETCH. A hit goes to DONE on the next edge with no memory request: 1-cycle latency, `mem_req` stays 0.
  - Each miss fill writes the line on the transition into DONE.
- Not defined: every fetch goes to memory; no cache storage is synthesized.

## Structure
- Shared package `cpu_defs`: `INST_W = 32`, `ADDR_W = 32`, `STALL_W = 6`, the stall bit indices `STALL_IF = 0` and `STALL_IFID = 1`, and the fetch state enum (IDLE, FETCH, DONE).
- One sub-module `if_icache` (lookup/fill, valid/tag/data arrays), instantiated only under `IF_ICACHE_EN`.

## Test plan
- Reset then memory returning 13, 05, 50, 00 at 0..3 with L = 1 → `output_pc = 0`, `output_instru = 32'h00500513` 4 cycles after FETCH; next `mem_addr = 4`.
- `stall_in = 6'b000011` held 5 cycles in DONE → outputs stable, `mem_req = 0`; release → fetch at `pc + 4`.
- `branch_or_not` with `branch_target = 32'h1000` after 2 acks, plus a stray ack the next cycle → stray ack dropped, outputs 0, fetch restarts at 0x1000 byte 0.
- PC 32'hFFFFFFFC, no stall → next `mem_addr = 0`.
- `rdy_in = 0` for 3 cycles mid-fetch → `byte_cnt` and `mem_addr` unchanged; fetch completes correctly afterwards.
- With `IF_ICACHE_EN`, loop branch back to 0x0 → second fetch of 0x0 in DONE 1 cycle after FETCH with `mem_req` never asserted.
